// File: rtl/shiftreg_1024_64.sv
// Parallel-to-serial output stage: takes one LANE_W*BEATS vector and emits it
// as BEATS sequential LANE_W beats, least-significant beat first, with a hold slot.
module shiftreg_1024_64 #(
  parameter int LANE_W = 64,
  parameter int BEATS  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANE_W*BEATS-1:0] x_1024,
  input  logic                    x_1024_valid,
  output logic                    x_1024_ready,
  output logic [LANE_W-1:0]       y_64,
  output logic                    y_64_valid,
  input  logic                    next_ready,
  output logic                    y_64_last
);

  localparam int VEC_W = LANE_W * BEATS;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic [VEC_W-1:0] r_actReg;
  logic             r_actValid;
  logic [VEC_W-1:0] r_holdReg;
  logic             r_holdValid;
  logic [CNT_W-1:0] r_beatCnt;

  logic w_rx;
  logic w_tx;
  logic w_txLast;

  assign x_1024_ready = !r_holdValid;
  assign y_64_valid   = r_actValid;
  assign y_64         = r_actReg[LANE_W-1:0];
  assign y_64_last    = r_actValid && (r_beatCnt == LAST_BEAT);

  assign w_rx     = x_1024_valid && x_1024_ready;
  assign w_tx     = y_64_valid && next_ready;
  assign w_txLast = w_tx && y_64_last;

  // On the final beat the next vector comes from hold first, else straight
  // from the input, so a ready sink never sees a bubble between vectors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_actReg    <= '0;
      r_actValid  <= 1'b0;
      r_holdReg   <= '0;
      r_holdValid <= 1'b0;
      r_beatCnt   <= '0;
    end else if (w_txLast) begin
      r_beatCnt <= '0;
      if (r_holdValid) begin
        r_actReg    <= r_holdReg;
        r_holdReg   <= '0;
        r_holdValid <= 1'b0;
      end else if (w_rx) begin
        r_actReg <= x_1024;
      end else begin
        r_actReg   <= '0;
        r_actValid <= 1'b0;
      end
    end else begin
      if (w_tx) begin
        r_actReg  <= r_actReg >> LANE_W;
        r_beatCnt <= r_beatCnt + CNT_W'(1);
      end
      if (w_rx) begin
        if (!r_actValid) begin
          r_actReg   <= x_1024;
          r_actValid <= 1'b1;
          r_beatCnt  <= '0;
        end else begin
          r_holdReg   <= x_1024;
          r_holdValid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_shiftreg_1024_64.sv
// Directed bench for shiftreg_1024_64: streams vectors under various sink
// patterns and checks beat order, last flags, ready and async reset.
module tb_shiftreg_1024_64;

  logic          clk;
  logic          rst;
  logic [1023:0] x_1024;
  logic          x_1024_valid;
  logic          x_1024_ready;
  logic [63:0]   y_64;
  logic          y_64_valid;
  logic          next_ready;
  logic          y_64_last;

  int errors = 0;
  int checks = 0;
  int cycles;

  shiftreg_1024_64 #(.LANE_W(64), .BEATS(16)) dut (
    .clk(clk),
    .rst(rst),
    .x_1024(x_1024),
    .x_1024_valid(x_1024_valid),
    .x_1024_ready(x_1024_ready),
    .y_64(y_64),
    .y_64_valid(y_64_valid),
    .next_ready(next_ready),
    .y_64_last(y_64_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Beat k of test vector v: bytes {k+v, k}; vector 0 gives {16{k}}.
  function automatic logic [63:0] expBeat(input int v, input int k);
    return {8{4'(k + v), 4'(k)}};
  endfunction

  function automatic logic [1023:0] makeVec(input int v);
    logic [1023:0] vec;
    for (int k = 0; k < 16; k++) vec[64*k +: 64] = expBeat(v, k);
    return vec;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1023:0] vec, input logic vld, input logic nrdy);
    x_1024       = vec;
    x_1024_valid = vld;
    next_ready   = nrdy;
  endtask

  // Offers nVec vectors back to back (vector ids base..) and checks every cycle
  // against a small occupancy model; the sink stalls for stallLen cycles from stallStart.
  task automatic runStream(input int nVec, input int base, input int stallStart,
                           input int stallLen, output int cyc);
    int   acc = 0;
    int   completed = 0;
    int   b = 0;
    logic pending = 1'b0;
    logic nrdy;
    cyc = 0;
    while (b < nVec * 16 && cyc < 400) begin
      if (pending) acc++;
      nrdy = !(cyc >= stallStart && cyc < stallStart + stallLen);
      applyStimulus(makeVec(base + acc), acc < nVec, nrdy);
      checkOutput("ready", x_1024_ready, (acc - completed) < 2);
      checkOutput("valid", y_64_valid, (acc - completed) > 0);
      if (y_64_valid) begin
        checkOutput($sformatf("beat%0d", b), y_64, expBeat(base + b / 16, b % 16));
        checkOutput($sformatf("last%0d", b), y_64_last, (b % 16) == 15);
        if (next_ready) begin
          b++;
          if (b % 16 == 0) completed++;
        end
      end
      pending = x_1024_valid && x_1024_ready;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 400) begin
      checks++;
      errors++;
      $display("[TB] FAIL stream_timeout beats=%0d expected=%0d", b, nVec * 16);
    end
    applyStimulus('0, 1'b0, 1'b1);
    checkOutput("drained_valid", y_64_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus('0, 1'b0, 1'b0);
    #2;
    checkOutput("rst_ready", x_1024_ready, 1'b1);
    checkOutput("rst_valid", y_64_valid, 1'b0);
    checkOutput("rst_y", y_64, 64'h0);
    checkOutput("rst_last", y_64_last, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] single vector");
    runStream(1, 0, 0, 0, cycles);
    checkOutput("single_cycles", 64'(cycles), 64'd17);

    $display("[TB] back-to-back three vectors");
    runStream(3, 0, 0, 0, cycles);
    checkOutput("b2b_cycles", 64'(cycles), 64'd49);

    $display("[TB] back-pressure 1,0,0,1");
    runStream(1, 1, 3, 2, cycles);
    checkOutput("bp_cycles", 64'(cycles), 64'd19);

    $display("[TB] full buffer");
    runStream(3, 2, 0, 6, cycles);
    checkOutput("full_cycles", 64'(cycles), 64'd54);

    $display("[TB] rx on last beat, then async reset");
    applyStimulus(makeVec(3), 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus('0, 1'b0, 1'b1);
    for (int k = 0; k < 15; k++) begin
      checkOutput($sformatf("v3_beat%0d", k), y_64, expBeat(3, k));
      @(negedge clk);
    end
    checkOutput("v3_last", y_64_last, 1'b1);
    applyStimulus(makeVec(4), 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("sim_y", y_64, 64'h4040404040404040);
    checkOutput("sim_valid", y_64_valid, 1'b1);
    checkOutput("sim_last", y_64_last, 1'b0);
    checkOutput("sim_ready", x_1024_ready, 1'b1);
    applyStimulus(makeVec(6), 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus('0, 1'b0, 1'b1);
    checkOutput("hold_full_ready", x_1024_ready, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("v4_beat5", y_64, 64'h9595959595959595);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_ready", x_1024_ready, 1'b1);
    checkOutput("arst_valid", y_64_valid, 1'b0);
    checkOutput("arst_y", y_64, 64'h0);
    checkOutput("arst_last", y_64_last, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("post_rst_valid", y_64_valid, 1'b0);
    runStream(1, 5, 0, 0, cycles);
    checkOutput("post_rst_cycles", 64'(cycles), 64'd17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
